// File: rtl/sobel_stream_unit_if.sv
// rtl/sobel_stream_unit_if.sv - stream handshake bundle for sobel_stream_unit
//
// Purpose: groups the pixel input stream and the packed output stream.
// Ports (slave = engine side):
//   in_valid/in_ready/in_data    : LANES x 8-bit grey pixels per beat
//   out_valid/out_ready/out_data : LANES x 32-bit packed pixels per beat
//   out_last                     : final beat of a frame
interface sobel_stream_unit_if #(
  parameter int LANES = 16
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [8*LANES-1:0]    in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_data;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sobel_stream_unit.sv
// rtl/sobel_stream_unit.sv - streaming Sobel edge-magnitude engine with back-pressure
//
// Purpose: two-stage Sobel pipeline over LANES pixels per beat, runtime frame
// geometry, boundary zeroing, saturating magnitude and optional threshold.
// Ports:
//   clk, rst        : single clock, synchronous active-high reset
//   cfg_beats/rows  : frame geometry, latched on the first beat of a frame
//   cfg_mode/thresh : 0 = magnitude, 1 = threshold against cfg_thresh
//   s_if            : input/output streams (slave modport)
module sobel_stream_unit #(
  parameter int LANES     = 16,
  parameter int MAX_BEATS = 32,
  parameter int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BW-1:0]    cfg_beats,
  input  logic [15:0]      cfg_rows,
  input  logic             cfg_mode,
  input  logic [7:0]       cfg_thresh,
  sobel_stream_unit_if.slave s_if
);
  localparam int DW = 8 * LANES;
  localparam int AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  // Line buffers: r_l1 holds row r-1, r_l2 holds row r-2, indexed by column beat.
  logic [DW-1:0]  r_l1 [MAX_BEATS];
  logic [DW-1:0]  r_l2 [MAX_BEATS];

  logic [AW-1:0]  r_col;
  logic [15:0]    r_row;
  logic [BW-1:0]  r_beats;
  logic [15:0]    r_rows;
  logic           r_mode;
  logic [7:0]     r_thresh;

  logic           r_s1_valid, r_s1_col0, r_s1_top, r_s1_last, r_s1_mode;
  logic [7:0]     r_s1_thresh;
  logic [DW-1:0]  r_s1_cur, r_s1_up1, r_s1_up2;
  logic [15:0]    r_cy0, r_cy1, r_cy2;

  logic                  r_out_valid, r_out_last;
  logic [32*LANES-1:0]   r_out_data;

  logic           w_en, w_accept, w_first, w_col_last, w_row_last;
  logic [BW-1:0]  w_beats_cfg, w_beats;
  logic [15:0]    w_rows_cfg, w_rows;
  logic           w_mode;
  logic [7:0]     w_thresh;
  logic [DW+15:0] w_e0, w_e1, w_e2;
  logic [7:0]     w_m;
  logic [32*LANES-1:0] w_out_data;

  assign w_en          = !r_out_valid || s_if.out_ready;
  assign s_if.in_ready = w_en && !rst;
  assign w_accept      = s_if.in_valid && s_if.in_ready;
  assign w_first       = (r_col == '0) && (r_row == '0);

  always_comb begin
    w_beats_cfg = cfg_beats;
    if (cfg_beats == '0)
      w_beats_cfg = BW'(1);
    else if (cfg_beats > BW'(MAX_BEATS))
      w_beats_cfg = BW'(MAX_BEATS);
  end

  assign w_rows_cfg = (cfg_rows == 16'd0) ? 16'd1 : cfg_rows;

  // The first beat of a frame uses the live config; later beats use the latch.
  assign w_beats    = w_first ? w_beats_cfg : r_beats;
  assign w_rows     = w_first ? w_rows_cfg  : r_rows;
  assign w_mode     = w_first ? cfg_mode    : r_mode;
  assign w_thresh   = w_first ? cfg_thresh  : r_thresh;
  assign w_col_last = (BW'(r_col) == (w_beats - BW'(1)));
  assign w_row_last = (r_row == (w_rows - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_beats  <= BW'(1);
      r_rows   <= 16'd1;
      r_mode   <= 1'b0;
      r_thresh <= 8'd0;
    end else if (w_accept) begin
      if (w_first) begin
        r_beats  <= w_beats_cfg;
        r_rows   <= w_rows_cfg;
        r_mode   <= cfg_mode;
        r_thresh <= cfg_thresh;
      end
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? 16'd0 : (r_row + 16'd1);
      end else begin
        r_col <= r_col + AW'(1);
      end
    end
  end

  // Non-blocking writes give read-before-write: S1 captures the old contents.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_l1[r_col] <= s_if.in_data;
      r_l2[r_col] <= r_l1[r_col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_col0   <= 1'b0;
      r_s1_top    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_thresh <= 8'd0;
      r_s1_cur    <= '0;
      r_s1_up1    <= '0;
      r_s1_up2    <= '0;
      r_cy0       <= 16'd0;
      r_cy1       <= 16'd0;
      r_cy2       <= 16'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_cur    <= s_if.in_data;
        r_s1_up1    <= r_l1[r_col];
        r_s1_up2    <= r_l2[r_col];
        r_s1_col0   <= (r_col == '0);
        r_s1_top    <= (r_row < 16'd2);
        r_s1_last   <= w_col_last && w_row_last;
        r_s1_mode   <= w_mode;
        r_s1_thresh <= w_thresh;
      end
      // Keep the two rightmost pixels of each row for the next beat's window.
      if (r_s1_valid) begin
        r_cy0      <= r_s1_up2[DW-1 -: 16];
        r_cy1      <= r_s1_up1[DW-1 -: 16];
        r_cy2      <= r_s1_cur[DW-1 -: 16];
        r_out_data <= w_out_data;
      end
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_valid && r_s1_last;
    end
  end

  // Extended rows: carry pixels sit to the left of the current beat.
  assign w_e0 = {r_s1_up2, r_s1_col0 ? 16'h0000 : r_cy0};
  assign w_e1 = {r_s1_up1, r_s1_col0 ? 16'h0000 : r_cy1};
  assign w_e2 = {r_s1_cur, r_s1_col0 ? 16'h0000 : r_cy2};

  // win = {w22, w21, w20, w12, w10, w02, w01, w00}; the centre pixel has zero weight.
  function automatic logic [7:0] f_pix(input logic [63:0] win, input logic bnd,
                                       input logic mode, input logic [7:0] th);
    logic [9:0]         gxp, gxn, gyp, gyn;
    logic signed [10:0] gx, gy;
    logic [10:0]        ax, ay;
    logic [11:0]        mag;
    gxp = {2'b00, win[23:16]} + {1'b0, win[39:32], 1'b0} + {2'b00, win[63:56]};
    gxn = {2'b00, win[7:0]}   + {1'b0, win[31:24], 1'b0} + {2'b00, win[47:40]};
    gyp = {2'b00, win[47:40]} + {1'b0, win[55:48], 1'b0} + {2'b00, win[63:56]};
    gyn = {2'b00, win[7:0]}   + {1'b0, win[15:8],  1'b0} + {2'b00, win[23:16]};
    gx  = $signed({1'b0, gxp}) - $signed({1'b0, gxn});
    gy  = $signed({1'b0, gyp}) - $signed({1'b0, gyn});
    ax  = gx[10] ? (~gx + 11'sd1) : gx;
    ay  = gy[10] ? (~gy + 11'sd1) : gy;
    mag = {1'b0, ax} + {1'b0, ay};
    if (bnd)
      f_pix = 8'd0;
    else if (mode)
      f_pix = (mag >= {4'h0, th}) ? 8'hff : 8'h00;
    else
      f_pix = (mag > 12'd255) ? 8'hff : mag[7:0];
  endfunction

  always_comb begin
    w_out_data = '0;
    w_m        = 8'd0;
    for (int j = 0; j < LANES; j++) begin
      w_m = f_pix({w_e2[8*j+16 +: 8], w_e2[8*j+8 +: 8], w_e2[8*j +: 8],
                   w_e1[8*j+16 +: 8], w_e1[8*j +: 8],
                   w_e0[8*j+16 +: 8], w_e0[8*j+8 +: 8], w_e0[8*j +: 8]},
                  r_s1_top || (r_s1_col0 && (j < 2)), r_s1_mode, r_s1_thresh);
      w_out_data[32*j +: 32] = {8'h00, w_m, w_m, w_m};
    end
  end

  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = r_out_data;
  assign s_if.out_last  = r_out_last;
endmodule

// File: tb/tb_sobel_stream_unit.sv
// tb/tb_sobel_stream_unit.sv - directed self-checking bench for sobel_stream_unit
module tb_sobel_stream_unit;
  localparam int LANES     = 16;
  localparam int MAX_BEATS = 32;
  localparam int BW        = $clog2(MAX_BEATS + 1);
  localparam int FLAT = 0, VEDGE = 1, RAMP = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [BW-1:0]   cfg_beats;
  logic [15:0]     cfg_rows;
  logic            cfg_mode;
  logic [7:0]      cfg_thresh;

  sobel_stream_unit_if #(.LANES(LANES)) s_if ();

  sobel_stream_unit #(.LANES(LANES), .MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_beats  (cfg_beats),
    .cfg_rows   (cfg_rows),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .s_if       (s_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit stall_en = 1'b0;

  logic [32*LANES-1:0] q_data [$];
  logic                q_last [$];

  task automatic check_eq(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int kind, input int c);
    logic [7:0] p;
    p = 8'h00;
    if (kind == FLAT)  p = 8'h80;
    if (kind == VEDGE) p = (c >= 16) ? 8'hff : 8'h00;
    if (kind == RAMP)  p = 8'((4 * c) & 255);
    return p;
  endfunction

  function automatic logic [8*LANES-1:0] build_beat(input int kind, input int col);
    logic [8*LANES-1:0] d;
    d = '0;
    for (int j = 0; j < LANES; j++) d[8*j +: 8] = pix(kind, col * LANES + j);
    return d;
  endfunction

  // Hand-derived results: vertical edge saturates at c = 16,17; ramp of slope 4 gives 32.
  function automatic logic [32*LANES-1:0] exp_beat(input int kind, input int row, input int col,
                                                   input int mode, input int th);
    logic [32*LANES-1:0] e;
    logic [7:0] m;
    int c;
    e = '0;
    for (int j = 0; j < LANES; j++) begin
      c = col * LANES + j;
      m = 8'h00;
      if (kind == VEDGE && row >= 2 && (c == 16 || c == 17)) m = 8'hff;
      if (kind == RAMP && row >= 2 && c >= 2) m = (mode != 0) ? ((32 >= th) ? 8'hff : 8'h00) : 8'd32;
      e[32*j +: 32] = {8'h00, m, m, m};
    end
    return e;
  endfunction

  initial begin
    s_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_if.out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    logic                hold;
    logic [32*LANES-1:0] prev_data;
    logic                prev_last;
    hold = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (hold && !rst)
        check_eq("stall_hold", {s_if.out_valid, s_if.out_last, s_if.out_data},
                 {1'b1, prev_last, prev_data});
      hold      = s_if.out_valid && !s_if.out_ready && !rst;
      prev_data = s_if.out_data;
      prev_last = s_if.out_last;
      if (s_if.out_valid && s_if.out_ready && !rst) begin
        q_data.push_back(s_if.out_data);
        q_last.push_back(s_if.out_last);
      end
    end
  end

  task automatic drive_beats(input int kind, input int start, input int count,
                             input int beats, input bit gaps);
    int t;
    for (int idx = start; idx < start + count; idx++) begin
      if (gaps) begin
        while ($urandom_range(0, 9) < 3) begin
          s_if.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_if.in_valid = 1'b1;
      s_if.in_data  = build_beat(kind, idx % beats);
      t = 0;
      forever begin
        @(negedge clk);
        if (s_if.in_ready) begin
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
        #1;
        t++;
        if (t > 1000) begin
          check_eq("in_ready_timeout", s_if.in_ready, 1);
          s_if.in_valid = 1'b0;
          return;
        end
      end
    end
    s_if.in_valid = 1'b0;
  endtask

  task automatic verify_frame(input int kind, input int beats, input int rows,
                              input int mode, input int th, input string tag);
    int n, t, got;
    n = beats * rows;
    t = 0;
    while (q_data.size() < n && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    got = q_data.size();
    check_eq($sformatf("%s_count", tag), got, n);
    for (int i = 0; i < n && i < got; i++) begin
      check_eq($sformatf("%s_r%0dc%0d", tag, i / beats, i % beats), q_data[i],
               exp_beat(kind, i / beats, i % beats, mode, th));
      check_eq($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1));
    end
    q_data.delete();
    q_last.delete();
  endtask

  task automatic set_cfg(input int beats, input int rows, input bit mode, input int th);
    cfg_beats  = BW'(beats);
    cfg_rows   = 16'(rows);
    cfg_mode   = mode;
    cfg_thresh = 8'(th);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    set_cfg(2, 4, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", s_if.in_ready, 0);
    check_eq("rst_out_valid", s_if.out_valid, 0);
    check_eq("rst_out_data", s_if.out_data, 0);
    check_eq("rst_out_last", s_if.out_last, 0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", s_if.in_ready, 1);

    // Latency: single-beat, single-row frame appears two cycles after acceptance.
    set_cfg(1, 1, 1'b0, 0);
    s_if.in_valid = 1'b1;
    s_if.in_data  = build_beat(RAMP, 0);
    @(negedge clk);
    check_eq("lat_in_ready", s_if.in_ready, 1);
    @(posedge clk);
    #1;
    s_if.in_valid = 1'b0;
    check_eq("lat_t1_valid", s_if.out_valid, 0);
    @(posedge clk);
    #1;
    check_eq("lat_t2_valid", s_if.out_valid, 1);
    check_eq("lat_t2_last", s_if.out_last, 1);
    verify_frame(RAMP, 1, 1, 0, 0, "lat");

    set_cfg(2, 4, 1'b0, 0);
    drive_beats(FLAT, 0, 8, 2, 1'b0);
    verify_frame(FLAT, 2, 4, 0, 0, "flat");

    drive_beats(VEDGE, 0, 8, 2, 1'b0);
    verify_frame(VEDGE, 2, 4, 0, 0, "vedge");

    set_cfg(2, 3, 1'b0, 0);
    drive_beats(RAMP, 0, 6, 2, 1'b0);
    verify_frame(RAMP, 2, 3, 0, 0, "ramp_m0");
    set_cfg(2, 3, 1'b1, 32);
    drive_beats(RAMP, 0, 6, 2, 1'b0);
    verify_frame(RAMP, 2, 3, 1, 32, "ramp_t32");
    set_cfg(2, 3, 1'b1, 33);
    drive_beats(RAMP, 0, 6, 2, 1'b0);
    verify_frame(RAMP, 2, 3, 1, 33, "ramp_t33");

    // cfg_beats = 0 behaves as one beat per line: lanes 0,1 are left boundary.
    set_cfg(0, 3, 1'b0, 0);
    drive_beats(RAMP, 0, 3, 1, 1'b0);
    verify_frame(RAMP, 1, 3, 0, 0, "beats0");

    set_cfg(2, 2, 1'b0, 0);
    drive_beats(VEDGE, 0, 4, 2, 1'b0);
    verify_frame(VEDGE, 2, 2, 0, 0, "rows2");

    set_cfg(2, 4, 1'b0, 0);
    stall_en = 1'b1;
    drive_beats(VEDGE, 0, 8, 2, 1'b1);
    verify_frame(VEDGE, 2, 4, 0, 0, "bp");
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after five beats of a frame, then a clean frame.
    drive_beats(VEDGE, 0, 5, 2, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", s_if.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_out_valid", s_if.out_valid, 0);
    q_data.delete();
    q_last.delete();
    drive_beats(VEDGE, 0, 8, 2, 1'b0);
    verify_frame(VEDGE, 2, 4, 0, 0, "post_rst");

    // Mode change mid-frame applies only from the next frame.
    set_cfg(2, 3, 1'b0, 32);
    drive_beats(RAMP, 0, 2, 2, 1'b0);
    cfg_mode = 1'b1;
    drive_beats(RAMP, 2, 4, 2, 1'b0);
    verify_frame(RAMP, 2, 3, 0, 32, "latch_a");
    drive_beats(RAMP, 0, 6, 2, 1'b0);
    verify_frame(RAMP, 2, 3, 1, 32, "latch_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_stream_unit.md
# sobel_stream_unit

Parametrised streaming Sobel edge-magnitude engine, successor to the fixed 16-lane, 512-pixel-line Sobel unit in the sobel sample accelerator. It accepts LANES 8-bit grey pixels per beat in raster order and produces one packed 32-bit output pixel per input pixel. Compared with the fixed unit, it adds:
- runtime frame geometry,
- explicit frame-boundary zeroing,
- saturating magnitude,
- an optional threshold mode,
- full valid/ready back-pressure on both sides.

It sits between the CCI read-path unpacker and the write-path packer.

## Interface
Parameters:
- LANES, 16, pixels per beat (≥2).
- MAX_BEATS, 32, maximum line length in beats; line buffer depth.
- BW, $clog2(MAX_BEATS+1), width of cfg_beats.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_beats  in  BW  line length in beats; 0 treated as 1; values >MAX_BEATS clamped to MAX_BEATS.
- cfg_rows  in  16  frame height in rows; 0 treated as 1.
- cfg_mode  in  1  0 = magnitude, 1 = threshold.
- cfg_thresh  in  8  threshold for mode 1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  8*LANES  pixel j at [8j +: 8]; lower j = further left.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  32*LANES  pixel j at [32j +: 32] = {8'h00, m, m, m}.
- out_last  out  1  marks the final beat of a frame.

## Operation
- cfg_* are sampled on the first accepted beat of each frame (row 0, beat 0) and held for the whole frame. Changes mid-frame are ignored.
- Counters col (0..cfg_beats-1) and row (0..cfg_rows-1) advance once per accepted beat.
  - col wraps to 0 and increments row.
  - After the last beat (row = cfg_rows-1, col = cfg_beats-1) both return to 0. The next beat starts a new frame.
- Line buffers: two RAMs of MAX_BEATS × 8*LANES, indexed by col.
  - On acceptance, L1[col] returns row r-1 and L2[col] returns row r-2.
  - Then L1[col] ← in_data and L2[col] ← old L1[col].
  - Read-before-write ordering is required.
  - Contents are not cleared by reset or at frame start; stale data is masked by the boundary rule.
- Column carry: the last two pixels of the previous beat for each of the three rows.
  - Forced to 0 when col = 0, so lines never wrap into each other.
- Window for output pixel at absolute column c = col*LANES + j, row r: w[y][x] = pixel(r-2+y, c-2+x), for y, x in 0..2.
  - The output is aligned to the bottom-right window pixel, which is the input pixel.
- Arithmetic, using signed 11-bit intermediates:
  - gx = (w02 + 2w12 + w22) − (w00 + 2w10 + w20)
  - gy = (w20 + 2w21 + w22) − (w00 + 2w01 + w02)
  - mag = |gx| + |gy|, 12 bits unsigned, maximum 2040.
- Output value m:
  - m = 0 if r < 2 or c < 2 (boundary).
  - Otherwise, mode 0: m = min(mag, 255).
  - Otherwise, mode 1: m = (mag ≥ cfg_thresh) ? 255 : 0.
- out_last = 1 on the output beat produced from the frame's final input beat; otherwise 0.

## Timing
- Two-stage pipeline.
  - S1 registers the input beat, col/row flags and the RAM read data.
  - S2 computes m and registers out_data and out_last.
- Global enable en = !out_valid || out_ready. The whole pipeline advances only when en = 1.
- in_ready = en && !rst (combinational).
- Latency: a beat accepted at cycle T appears with out_valid = 1 at T+2 when out_ready is held high.
- Throughput is 1 beat/cycle.
- While out_valid && !out_ready: out_data, out_last and out_valid are held stable, and no input is accepted.
- Bubbles (in_valid = 0) propagate as out_valid = 0 and do not advance counters.
- Reset values: out_valid = 0, out_data = 0, out_last = 0, col = 0, row = 0, pipeline valids = 0.
- Reset mid-frame discards in-flight beats. The first beat accepted after rst falls is row 0, col 0.
- cfg_beats = 1: every beat has col = 0, so pixels j < 2 are always boundary.
- cfg_rows = 1 or 2: every output is 0, and out_last is still asserted on the final beat.

## Test plan
- Flat frame: cfg_beats = 2, cfg_rows = 4, all pixels 0x80, mode 0 → every out_data pixel = 32'h0000_0000; out_last only on beat 8.
- Vertical edge: cfg_beats = 2, rows = 4, LANES = 16, pixel = (c ≥ 16) ? 255 : 0 → in rows 2-3, columns 16 and 17 give m = 255 (gx = 1020, saturated); all others give 0; rows 0-1 are all 0.
- Ramp / threshold: pixel = 4c, rows = 3, beats = 2.
  - mode 0: row 2, c ≥ 2 gives m = 32.
  - mode 1 with thresh = 32: m = 255.
  - mode 1 with thresh = 33: m = 0.
- Back-pressure: repeat the vertical-edge frame with out_ready randomly low 50% and in_valid randomly low 30% → output sequence bit-identical to the unstalled run; data stable during stalls; no lost or duplicate beats.
- Reset mid-frame: assert rst for 1 cycle after 5 beats, then send a full 4-row frame → out_valid = 0 the cycle after reset; the new frame's output matches a clean-run reference, with rows 0-1 all zero despite stale RAMs.
- Config latch: change cfg_mode 0 → 1 mid-frame → that frame stays in mode 0; the next frame uses mode 1.
